// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_if
//  Brief    : ID/EX/MEM hazard-control signal bundle for pipeline_hazard_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [0:4]       ID_rA;
    logic [0:4]       ID_rB;
    logic             ID_useA;
    logic             ID_useB;
    logic             ID_branch_taken;
    logic [0:4]       EX_rD;
    logic             EX_wrEn;
    logic             EX_memRd;
    logic [0:4]       EX_MEM_rD;
    logic             EX_MEM_wrEn;
    logic             EX_MEM_memRd;
    logic             mem_req;
    logic             mem_ready;
    logic             clr_counters;

    logic             ID_forward_rA;
    logic             ID_forward_rB;
    logic             stall_IF;
    logic             stall_ID;
    logic             bubble_EX;
    logic             flush_IF_ID;
    logic             freeze;
    logic             mem_err;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_rA, ID_rB, ID_useA, ID_useB, ID_branch_taken,
               EX_rD, EX_wrEn, EX_memRd, EX_MEM_rD, EX_MEM_wrEn, EX_MEM_memRd,
               mem_req, mem_ready, clr_counters,
        input  ID_forward_rA, ID_forward_rB, stall_IF, stall_ID, bubble_EX,
               flush_IF_ID, freeze, mem_err, stall_count, flush_count
    );

    modport slave (
        input  ID_rA, ID_rB, ID_useA, ID_useB, ID_branch_taken,
               EX_rD, EX_wrEn, EX_memRd, EX_MEM_rD, EX_MEM_wrEn, EX_MEM_memRd,
               mem_req, mem_ready, clr_counters,
        output ID_forward_rA, ID_forward_rB, stall_IF, stall_ID, bubble_EX,
               flush_IF_ID, freeze, mem_err, stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : RAW hazard detect, ID forwarding, stall/flush, memory freeze.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    pipeline_hazard_ctrl_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_exA, w_exB, w_exmA, w_exmB, w_hazard;
    logic w_fwdA, w_fwdB, w_stall, w_flush, w_freeze;
    logic w_unused_ex_memrd;

    // A load in EX is caught by the plain EX match; it stalls again from EX/MEM.
    assign w_unused_ex_memrd = bus.EX_memRd;

    assign w_exA  = bus.ID_useA && (|bus.ID_rA) && (bus.ID_rA == bus.EX_rD)     && bus.EX_wrEn;
    assign w_exB  = bus.ID_useB && (|bus.ID_rB) && (bus.ID_rB == bus.EX_rD)     && bus.EX_wrEn;
    assign w_exmA = bus.ID_useA && (|bus.ID_rA) && (bus.ID_rA == bus.EX_MEM_rD) && bus.EX_MEM_wrEn;
    assign w_exmB = bus.ID_useB && (|bus.ID_rB) && (bus.ID_rB == bus.EX_MEM_rD) && bus.EX_MEM_wrEn;

    assign w_hazard = w_exA || w_exB || ((w_exmA || w_exmB) && bus.EX_MEM_memRd);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mem_err_d = mem_err_q;
        w_fwdA    = 1'b0;
        w_fwdB    = 1'b0;
        w_stall   = 1'b0;
        w_flush   = 1'b0;
        w_freeze  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    w_freeze = 1'b1;
                    state_d  = ST_MEMWAIT;
                    timer_d  = TW'(1);
                end else if (w_hazard) begin
                    w_stall = 1'b1;
                end else begin
                    w_flush = bus.ID_branch_taken;
                    w_fwdA  = w_exmA && !bus.EX_MEM_memRd;
                    w_fwdB  = w_exmB && !bus.EX_MEM_memRd;
                end
            end
            ST_MEMWAIT: begin
                w_freeze = 1'b1;
                if (bus.mem_ready) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else if (timer_q == c_TIMER_LAST) begin
                    // Access abandoned; the error stays latched until reset.
                    mem_err_d = 1'b1;
                    state_d   = ST_RUN;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.clr_counters) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((w_stall || w_freeze) && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (w_flush && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            timer_q     <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ID_forward_rA = w_fwdA;
    assign bus.ID_forward_rB = w_fwdB;
    assign bus.stall_IF      = w_stall;
    assign bus.stall_ID      = w_stall;
    assign bus.bubble_EX     = w_stall;
    assign bus.flush_IF_ID   = w_flush;
    assign bus.freeze        = w_freeze;
    assign bus.mem_err       = mem_err_q;
    assign bus.stall_count   = stall_cnt_q;
    assign bus.flush_count   = flush_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Directed plus random bench against a rule-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: waiting on memory, cycles spent, error, counter values.
    bit m_wait;
    int m_timer;
    bit m_err;
    int m_sc;
    int m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hit(input logic use_, input logic [4:0] rs, input logic [4:0] rd, input logic wr);
        return use_ && (rs != 5'd0) && (rs == rd) && wr;
    endfunction

    // Bit order: {fwdA, fwdB, stall_IF, stall_ID, bubble_EX, flush, freeze}
    function automatic logic [6:0] exp_comb();
        bit a_ex, b_ex, a_em, b_em, haz;
        logic [6:0] e;
        a_ex = hit(bus.ID_useA, bus.ID_rA, bus.EX_rD, bus.EX_wrEn);
        b_ex = hit(bus.ID_useB, bus.ID_rB, bus.EX_rD, bus.EX_wrEn);
        a_em = hit(bus.ID_useA, bus.ID_rA, bus.EX_MEM_rD, bus.EX_MEM_wrEn);
        b_em = hit(bus.ID_useB, bus.ID_rB, bus.EX_MEM_rD, bus.EX_MEM_wrEn);
        haz  = a_ex || b_ex || (bus.EX_MEM_memRd && (a_em || b_em));
        e = '0;
        if (m_wait || (bus.mem_req && !bus.mem_ready)) e[0] = 1'b1;
        else if (haz) e[4:2] = 3'b111;
        else begin
            e[1] = bus.ID_branch_taken;
            e[6] = a_em && !bus.EX_MEM_memRd;
            e[5] = b_em && !bus.EX_MEM_memRd;
        end
        return e;
    endfunction

    function automatic logic [6:0] obs_comb();
        return {bus.ID_forward_rA, bus.ID_forward_rB, bus.stall_IF, bus.stall_ID,
                bus.bubble_EX, bus.flush_IF_ID, bus.freeze};
    endfunction

    task automatic set_in(input logic [4:0] ra, input logic [4:0] rb, input logic ua, input logic ub,
                          input logic br, input logic [4:0] exrd, input logic exwr, input logic exld,
                          input logic [4:0] emrd, input logic emwr, input logic emld,
                          input logic req, input logic rdy, input logic clr);
        bus.ID_rA = ra;       bus.ID_rB = rb;     bus.ID_useA = ua;      bus.ID_useB = ub;
        bus.ID_branch_taken = br;
        bus.EX_rD = exrd;     bus.EX_wrEn = exwr; bus.EX_memRd = exld;
        bus.EX_MEM_rD = emrd; bus.EX_MEM_wrEn = emwr; bus.EX_MEM_memRd = emld;
        bus.mem_req = req;    bus.mem_ready = rdy; bus.clr_counters = clr;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_wait = 0; m_timer = 0; m_err = 0; m_sc = 0; m_fc = 0;
    endtask

    // One clock: check outputs mid-cycle, advance model, check registers after the edge.
    task automatic cycle();
        logic [6:0] e;
        bit n_wait; int n_timer; bit n_err_f; int n_sc; int n_fc;
        @(negedge clk);
        e = exp_comb();
        chk("comb", {25'd0, obs_comb()}, {25'd0, e});
        n_wait = m_wait; n_timer = m_timer; n_err_f = m_err; n_sc = m_sc; n_fc = m_fc;
        if (m_wait) begin
            if (bus.mem_ready) n_wait = 0;
            else if (m_timer == TIMEOUT - 1) begin n_err_f = 1; n_wait = 0; end
            else n_timer = m_timer + 1;
        end else if (bus.mem_req && !bus.mem_ready) begin
            n_wait = 1; n_timer = 1;
        end
        if (bus.clr_counters) begin
            n_sc = 0; n_fc = 0;
        end else begin
            if ((e[3] || e[0]) && m_sc < CMAX) n_sc = m_sc + 1;
            if (e[1] && m_fc < CMAX) n_fc = m_fc + 1;
        end
        @(posedge clk);
        #1;
        m_wait = n_wait; m_timer = n_timer; m_err = n_err_f; m_sc = n_sc; m_fc = n_fc;
        chk("mem_err", {31'd0, bus.mem_err}, {31'd0, m_err});
        chk("stall_count", 32'(bus.stall_count), 32'(m_sc));
        chk("flush_count", 32'(bus.flush_count), 32'(m_fc));
    endtask

    task automatic clear_counters();
        idle(); bus.clr_counters = 1'b1;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        #12;
        chk("rst_comb", {25'd0, obs_comb()}, {25'd0, exp_comb()});
        chk("rst_err", {31'd0, bus.mem_err}, 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_count), 32'd0);
        chk("rst_flush_cnt", 32'(bus.flush_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ALU result in EX, then forwarded from EX/MEM
        set_in(5, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
        set_in(5, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); cycle();
        chk("alu_fwd_cnt", 32'(bus.stall_count), 32'd1);

        // Load in EX: two stalls, then nothing to forward
        clear_counters();
        set_in(0, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0); cycle();
        set_in(0, 7, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); cycle();
        set_in(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("load_stall_cnt", 32'(bus.stall_count), 32'd2);

        // r0 and unused operands never match
        set_in(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0); cycle();
        set_in(9, 9, 0, 0, 0, 9, 1, 1, 9, 1, 1, 0, 0, 0); cycle();

        // Taken branch, clean then under a hazard
        clear_counters();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("flush_cnt", 32'(bus.flush_count), 32'd1);
        set_in(3, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cycle();

        // Memory access completing after five wait cycles
        clear_counters();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        bus.mem_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        bus.mem_ready = 1'b1; cycle();
        idle(); cycle();
        chk("mem_ok_stall_cnt", 32'(bus.stall_count), 32'd6);
        chk("mem_ok_err", {31'd0, bus.mem_err}, 32'd0);

        // Memory access that never completes
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        bus.mem_req = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) cycle();
        chk("timeout_err", {31'd0, bus.mem_err}, 32'd1);

        // Counter saturation, then clear while stalled
        set_in(4, 0, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CMAX + 4; i++) cycle();
        chk("sat_cnt", 32'(bus.stall_count), 32'(CMAX));
        bus.clr_counters = 1'b1; cycle();
        chk("clr_cnt", 32'(bus.stall_count), 32'd0);
        bus.clr_counters = 1'b0;

        // Reset asserted while waiting on memory
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        bus.mem_req = 1'b0; cycle();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_midwait_freeze", {31'd0, bus.freeze}, 32'd0);
        chk("rst_midwait_err", {31'd0, bus.mem_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Random traffic over a small register set to provoke matches
        for (int i = 0; i < 600; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                   1'($urandom_range(0, 59) == 0));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
